imem_loader: RTL

Program loader that writes a byte stream into the instruction memory the pipeline fetches from, and holds the processor in reset until a complete image has been written. It sits between a byte source (UART receiver or testbench) and the instruction memory's write port. It drives the core's reset so the IF stage only starts fetching from PC 0 after a verified load. It is the writer side of the instruction-memory interface that the fetch stage reads.

---
 rtl/imem_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes a counted, little-endian word image into
// instruction memory and holds the core in reset until the image is complete.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter  int IM_MEM_DEPTH      = 256,
  parameter  int INSTRUCTION_WIDTH = 32,
  localparam int ADDRESS_WIDTH     = $clog2(IM_MEM_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         loadStart,
  input  logic [7:0]                   byteIn,
  input  logic                         byteValid,
  output logic                         byteReady,
  output logic                         imWrite,
  output logic [ADDRESS_WIDTH-1:0]     imAddr,
  output logic [INSTRUCTION_WIDTH-1:0] imData,
  output logic                         cpuRstN,
  output logic                         busy,
  output logic                         loadError
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic        w_byte_ready;
  logic        w_busy;
  logic        w_start;
  logic        w_xfer;
  logic        w_word_done;
  logic        w_last_word;
  logic [15:0] w_count_full;

  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_asm;
  logic        r_im_write;
  logic [ADDRESS_WIDTH-1:0]     r_im_addr;
  logic [INSTRUCTION_WIDTH-1:0] r_im_data;
  logic        r_cpu_rst_n;
  logic        r_load_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  assign w_xfer       = byteValid && w_byte_ready;
  assign w_count_full = {byteIn, r_count[7:0]};
  assign w_word_done  = w_xfer && (r_state == S_DATA) && (r_byte_idx == 2'd3);
  assign w_last_word  = (r_word_idx == (r_count - 16'd1));

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_byte_ready = 1'b0;
    w_busy       = 1'b0;
    w_start      = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (loadStart) begin
          w_start      = 1'b1;
          w_state_next = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (w_xfer) w_state_next = S_CNT_HI;
      end
      S_CNT_HI: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (w_xfer) begin
          if (w_count_full == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_state_next = S_CHECK;
`else
            w_state_next = S_DONE;
`endif
          else if ({1'b0, w_count_full} > 17'(IM_MEM_DEPTH))
            w_state_next = S_ERROR;
          else
            w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (w_word_done && w_last_word)
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = S_CHECK;
`else
          w_state_next = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
        if (w_xfer) w_state_next = (byteIn == r_csum) ? S_DONE : S_ERROR;
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: count capture, word assembly and the memory write port.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_asm        <= '0;
      r_im_write   <= 1'b0;
      r_im_addr    <= '0;
      r_im_data    <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_load_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_im_write  <= 1'b0;
      // Release the core only after a full cycle in DONE; a restart drops it at once.
      r_cpu_rst_n <= (r_state == S_DONE) && !loadStart;

      if (w_start) begin
        r_word_idx   <= '0;
        r_byte_idx   <= '0;
        r_load_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum       <= '0;
`endif
      end else if (w_state_next == S_ERROR) begin
        r_load_error <= 1'b1;
      end

      if (w_xfer) begin
        unique case (r_state)
          S_CNT_LO: r_count[7:0]  <= byteIn;
          S_CNT_HI: r_count[15:8] <= byteIn;
          S_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum + byteIn;
`endif
            if (r_byte_idx == 2'd3) begin
              // First byte received lands in bits 7:0 of the written word.
              r_im_data  <= {byteIn, r_asm};
              r_im_addr  <= r_word_idx[ADDRESS_WIDTH-1:0];
              r_im_write <= 1'b1;
              r_word_idx <= r_word_idx + 16'd1;
            end else begin
              r_asm <= {byteIn, r_asm[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign byteReady = w_byte_ready;
  assign busy      = w_busy;
  assign imWrite   = r_im_write;
  assign imAddr    = r_im_addr;
  assign imData    = r_im_data;
  assign cpuRstN   = r_cpu_rst_n;
  assign loadError = r_load_error;

endmodule
